// File: rtl/cp0_count_timer_pkg.sv
// Shared CP0 constants for the Count/Compare timer: register addresses,
// Count reset value and the Cause bit that carries the timer interrupt.
package cp0_count_timer_pkg;

   // Address encoding is {reg[4:0], sel[2:0]}, the same as the other cp0_* blocks.
   localparam logic [7:0]  cp0addr_Count   = {5'd9, 3'd0};
   localparam logic [7:0]  cp0addr_Compare = {5'd11, 3'd0};
   localparam logic [31:0] Count_ini       = 32'h0000_0000;
   localparam int          Cause_TI_bit    = 30;

endpackage

// File: rtl/cp0_count_timer_if.sv
// mtc0 write bus plus Compare input and Count/timer outputs of the CP0 timer.
// The master side is the CP0 top; the slave side is cp0_count_timer.
interface cp0_count_timer_if;

   logic        mtc0_we;
   logic [31:0] mtc0_data;
   logic [7:0]  cp0_addr;
   logic [31:0] cp0_Compare_data;
   logic [31:0] cp0_Count_data;
   logic        cp0_Cause_TI;
   logic        timer_int;

   modport master (
      output mtc0_we, mtc0_data, cp0_addr, cp0_Compare_data,
      input  cp0_Count_data, cp0_Cause_TI, timer_int
   );

   modport slave (
      input  mtc0_we, mtc0_data, cp0_addr, cp0_Compare_data,
      output cp0_Count_data, cp0_Cause_TI, timer_int
   );

endinterface

// File: rtl/cp0_count_timer.sv
// CP0 Count register (advances every second clock) and the Compare-match
// timer interrupt that sets Cause.TI and drives IP7.
module cp0_count_timer
   import cp0_count_timer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   cp0_count_timer_if.slave bus
);

   logic [31:0] count_q;
   logic        tick_q;
   logic        ti_q;
   logic        cmp_valid_q;

   logic        count_wr;
   logic        cmp_wr;
   logic        match;

   always_comb begin
      count_wr = bus.mtc0_we && (bus.cp0_addr == cp0addr_Count);
      cmp_wr   = bus.mtc0_we && (bus.cp0_addr == cp0addr_Compare);
      // Compare has no reset value; ignore it until software has written it once,
      // and skip the cycle of a Compare write so the stale value cannot fire.
      match    = cmp_valid_q && !cmp_wr && (count_q == bus.cp0_Compare_data);
   end

   // NOTE: all state uses <= so every branch reads the pre-edge values, which is
   // what lets a match in the same cycle as a Count write use the old Count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= Count_ini;
         tick_q      <= 1'b0;
         ti_q        <= 1'b0;
         cmp_valid_q <= 1'b0;
      end else begin
         tick_q <= count_wr ? 1'b0 : ~tick_q;

         if (count_wr)
            count_q <= bus.mtc0_data;
         else if (tick_q)
            count_q <= count_q + 32'd1;

         if (cmp_wr)
            cmp_valid_q <= 1'b1;

         // TI is sticky: only a Compare write clears it.
         if (cmp_wr)
            ti_q <= 1'b0;
         else if (match)
            ti_q <= 1'b1;
      end
   end

   assign bus.cp0_Count_data = count_q;
   assign bus.cp0_Cause_TI   = ti_q;
   assign bus.timer_int      = ti_q;

endmodule

// File: tb/tb_cp0_count_timer.sv
// Randomised and directed bench for cp0_count_timer; Count is modelled as
// (last written value + half the edges since), TI from the match rules.
module tb_cp0_count_timer;
   import cp0_count_timer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   cp0_count_timer_if bus ();

   cp0_count_timer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [7:0] addr_other = {5'd12, 3'd0};

   int          vectors = 0;
   int          errors  = 0;

   logic [31:0] m_base;
   int unsigned m_since;
   logic        m_ti;
   logic        m_valid;

   function automatic logic [31:0] m_count();
      return m_base + 32'(m_since >> 1);
   endfunction

   // One clock edge with the given inputs; the reference model advances on the same edge.
   task automatic cycle(input logic r, input logic we, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] c;
      logic        kw;
      logic        cw;
      rst_n         = r;
      bus.mtc0_we   = we;
      bus.cp0_addr  = a;
      bus.mtc0_data = d;
      @(posedge clk);
      c  = m_count();
      kw = we && (a == cp0addr_Count);
      cw = we && (a == cp0addr_Compare);
      if (!r) begin
         m_base  = Count_ini;
         m_since = 0;
         m_ti    = 1'b0;
         m_valid = 1'b0;
      end else begin
         if (cw)
            m_ti = 1'b0;
         else if (m_valid && c == bus.cp0_Compare_data)
            m_ti = 1'b1;
         if (cw)
            m_valid = 1'b1;
         if (kw) begin
            m_base  = d;
            m_since = 0;
         end else begin
            m_since++;
         end
      end
      #1;
      if (r && cw)
         bus.cp0_Compare_data = d;
      rst_n       = 1'b1;
      bus.mtc0_we = 1'b0;
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
      cycle(1'b0, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) idle();
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int} !== {exp_seq[i], 2'b00}) begin
            errors++;
            $display("FAIL reset_seq[%0d]: count=%h ti=%b int=%b, want count=%h ti=0 int=0",
                     i, bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int, exp_seq[i]);
         end
      end
   endtask

   task automatic test_compare_match();
      int budget;
      cycle(1'b1, 1'b1, cp0addr_Count, 32'h0000_0010);
      cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0014);
      budget = 40;
      while (bus.cp0_Count_data !== 32'h14 && budget > 0) begin
         idle();
         budget--;
      end
      if (budget == 0) begin
         vectors++;
         errors++;
         $display("FAIL match_wait: count=%h never reached 00000014", bus.cp0_Count_data);
      end
      vectors++;
      if (bus.cp0_Cause_TI !== 1'b0) begin
         errors++;
         $display("FAIL match_early: ti=%b when count first 14, want 0", bus.cp0_Cause_TI);
      end
      for (int i = 0; i < 12; i++) begin
         idle();
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int} !== {m_count(), 2'b11}) begin
            errors++;
            $display("FAIL match_hold[%0d]: count=%h ti=%b int=%b, want count=%h ti=1 int=1",
                     i, bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int, m_count());
         end
      end
   endtask

   task automatic test_compare_clear();
      int budget;
      cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0100);
      vectors++;
      if (bus.cp0_Cause_TI !== 1'b0 || bus.timer_int !== 1'b0) begin
         errors++;
         $display("FAIL clear: ti=%b int=%b after Compare write, want 0", bus.cp0_Cause_TI, bus.timer_int);
      end
      budget = 1000;
      while (bus.cp0_Count_data !== 32'h100 && budget > 0) begin
         idle();
         budget--;
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI} !== {m_count(), 1'b0}) begin
            errors++;
            $display("FAIL clear_hold: count=%h ti=%b, want count=%h ti=0",
                     bus.cp0_Count_data, bus.cp0_Cause_TI, m_count());
         end
      end
      if (budget == 0) begin
         vectors++;
         errors++;
         $display("FAIL clear_wait: count=%h never reached 00000100", bus.cp0_Count_data);
      end
      idle();
      vectors++;
      if (bus.cp0_Cause_TI !== 1'b1) begin
         errors++;
         $display("FAIL clear_rearm: ti=%b one cycle after count=100, want 1", bus.cp0_Cause_TI);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h0, 32'h0, 32'h1, 32'h1};
      logic        exp_ti  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         if (i == 0)
            cycle(1'b1, 1'b1, cp0addr_Count, 32'hFFFF_FFFE);
         else if (i == 1)
            cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0001);
         else
            idle();
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI} !== {exp_seq[i], exp_ti[i]}) begin
            errors++;
            $display("FAIL wrap[%0d]: count=%h ti=%b, want count=%h ti=%b",
                     i, bus.cp0_Count_data, bus.cp0_Cause_TI, exp_seq[i], exp_ti[i]);
         end
      end
   endtask

   task automatic test_no_compare();
      bus.cp0_Compare_data = 32'h0000_0003;
      cycle(1'b0, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 14; i++) begin
         idle();
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int} !== {m_count(), 2'b00}) begin
            errors++;
            $display("FAIL no_compare[%0d]: count=%h ti=%b int=%b, want count=%h ti=0 int=0",
                     i, bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int, m_count());
         end
      end
   endtask

   task automatic test_cmp_collision();
      int budget;
      cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0050);
      cycle(1'b1, 1'b1, cp0addr_Count, 32'h0000_0050);
      // Count now equals the old Compare while the new Compare is being written.
      cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0053);
      idle();
      vectors++;
      if (bus.cp0_Cause_TI !== 1'b0) begin
         errors++;
         $display("FAIL collision: ti=%b with Compare written at old match, want 0", bus.cp0_Cause_TI);
      end
      budget = 20;
      while (bus.cp0_Count_data !== 32'h53 && budget > 0) begin
         idle();
         budget--;
      end
      idle();
      vectors++;
      if (bus.cp0_Cause_TI !== 1'b1 || budget == 0) begin
         errors++;
         $display("FAIL collision_new: count=%h ti=%b, want count past 00000053 ti=1",
                  bus.cp0_Count_data, bus.cp0_Cause_TI);
      end
   endtask

   task automatic test_random();
      logic        r;
      logic        we;
      logic [7:0]  a;
      logic [31:0] d;
      int unsigned op;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 99) != 0);
         op = $urandom_range(0, 9);
         we = 1'b0;
         a  = 8'h00;
         d  = $urandom;
         if (r && op <= 1) begin
            we = 1'b1;
            a  = cp0addr_Count;
            if (op == 1) d = bus.cp0_Compare_data - 32'($urandom_range(0, 3));
         end else if (r && op <= 3) begin
            we = 1'b1;
            a  = cp0addr_Compare;
            d  = m_count() + 32'($urandom_range(0, 6));
         end else if (r && op == 4) begin
            we = 1'b1;
            a  = addr_other;
         end
         cycle(r, we, a, d);
         vectors++;
         if ({bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int} !== {m_count(), m_ti, m_ti}) begin
            errors++;
            $display("FAIL random[%0d]: count=%h ti=%b int=%b, want count=%h ti=%b int=%b",
                     i, bus.cp0_Count_data, bus.cp0_Cause_TI, bus.timer_int, m_count(), m_ti, m_ti);
         end
      end
   endtask

   initial begin
      bus.mtc0_we          = 1'b0;
      bus.mtc0_data        = 32'h0;
      bus.cp0_addr         = 8'h00;
      bus.cp0_Compare_data = 32'hDEAD_BEEF;
      m_base  = Count_ini;
      m_since = 0;
      m_ti    = 1'b0;
      m_valid = 1'b0;
      #2;
      test_reset();
      test_compare_match();
      test_compare_clear();
      test_wrap();
      test_no_compare();
      test_cmp_collision();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
